// File: rtl/pipeline_ctrl_if.sv
// Latch-control bundle between the hazard controller (master) and the pipeline datapath (slave).
// Carries hazard inputs, register enables/flushes, halt and the stall counters.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_req;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_dren;
    logic [4:0]       ex_rt;
    logic             ex_redirect;
    logic             mem_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             halt;
    logic [CNT_W-1:0] luse_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        input  ihit, dhit, mem_req, id_rs, id_rt, id_uses_rt, ex_dren, ex_rt, ex_redirect,
               mem_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt,
               luse_cnt, wait_cnt
    );

    modport slave (
        output ihit, dhit, mem_req, id_rs, id_rt, id_uses_rt, ex_dren, ex_rt, ex_redirect,
               mem_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt,
               luse_cnt, wait_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, memory-wait freezes,
// fetch-stall drains, redirect flushes and a sticky halt, plus saturating stall counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic              CLK,
    input logic              RST,
    pipeline_ctrl_if.master  bus
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic             ihit_seen_q, ihit_seen_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] luse_q, luse_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic ifetch, dok, adv, lu;
    logic luse_inc, wait_inc;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;

    always_comb begin
        ifetch = bus.ihit | ihit_seen_q;
        dok    = ~bus.mem_req | bus.dhit;
        adv    = ifetch & dok;
        lu     = bus.ex_dren & (bus.ex_rt != 5'd0) &
                 ((bus.ex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));
    end

    always_comb begin
        state_d     = state_q;
        ihit_seen_d = ihit_seen_q;
        luse_inc    = 1'b0;
        wait_inc    = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;

        unique case (state_q)
            StRun: begin
                // The cache holds a completed fetch, so remember it across a memory stall.
                if (adv) begin
                    ihit_seen_d = 1'b0;
                end else if (bus.ihit) begin
                    ihit_seen_d = 1'b1;
                end

                if (bus.mem_halt) begin
                    state_d = StHalted;
                end else if (!adv && dok && !bus.ex_redirect) begin
                    // Fetch stall: let the back end drain behind a bubble.
                    wait_inc   = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (!adv) begin
                    // Freeze everything, keeping a pending redirect intact.
                    wait_inc = 1'b1;
                end else if (bus.ex_redirect) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (lu) begin
                    luse_inc   = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        halt_d = (state_d == StHalted);
        luse_d = (luse_inc && (luse_q != CntMax)) ? luse_q + CNT_W'(1) : luse_q;
        wait_d = (wait_inc && (wait_q != CntMax)) ? wait_q + CNT_W'(1) : wait_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StRun;
            ihit_seen_q <= 1'b0;
            halt_q      <= 1'b0;
            luse_q      <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            ihit_seen_q <= ihit_seen_d;
            halt_q      <= halt_d;
            luse_q      <= luse_d;
            wait_q      <= wait_d;
        end
    end

    // Combinational controls must be quiet while reset is held, not just after it.
    assign bus.pc_en      = pc_en & ~RST;
    assign bus.ifid_en    = ifid_en & ~RST;
    assign bus.ifid_flush = ifid_flush & ~RST;
    assign bus.idex_en    = idex_en & ~RST;
    assign bus.idex_flush = idex_flush & ~RST;
    assign bus.exmem_en   = exmem_en & ~RST;
    assign bus.memwb_en   = memwb_en & ~RST;
    assign bus.halt       = halt_q;
    assign bus.luse_cnt   = luse_q;
    assign bus.wait_cnt   = wait_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then randomized traffic,
// compared against a priority-table reference model of the controller.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 5;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    localparam int ActIdle     = 0;
    localparam int ActHalt     = 1;
    localparam int ActDrain    = 2;
    localparam int ActFreeze   = 3;
    localparam int ActRedirect = 4;
    localparam int ActBubble   = 5;
    localparam int ActRun      = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int checks = 0;
    int errors = 0;

    bit          m_halted;
    bit          m_seen;
    int unsigned m_luse;
    int unsigned m_wait;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_halted = 0;
        m_seen   = 0;
        m_luse   = 0;
        m_wait   = 0;
    endtask

    // Enables packed as {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb}.
    task automatic model_eval(output logic [6:0] en, output int act);
        bit fetched, mem_ok, go, hazard;
        fetched = bus.ihit || m_seen;
        mem_ok  = !bus.mem_req || bus.dhit;
        go      = fetched && mem_ok;
        hazard  = bus.ex_dren && (bus.ex_rt != 0) &&
                  ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        if (RST || m_halted)                        begin en = 7'b0000000; act = ActIdle;     end
        else if (bus.mem_halt)                      begin en = 7'b0000000; act = ActHalt;     end
        else if (!go && mem_ok && !bus.ex_redirect) begin en = 7'b0001111; act = ActDrain;    end
        else if (!go)                               begin en = 7'b0000000; act = ActFreeze;   end
        else if (bus.ex_redirect)                   begin en = 7'b1111111; act = ActRedirect; end
        else if (hazard)                            begin en = 7'b0001111; act = ActBubble;   end
        else                                        begin en = 7'b1101011; act = ActRun;      end
    endtask

    task automatic cycle(input string tag);
        logic [6:0] en;
        int         act;
        @(negedge CLK);
        if (RST) model_reset();
        model_eval(en, act);
        chk({tag, ".en"}, {25'd0, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                           bus.idex_flush, bus.exmem_en, bus.memwb_en}, {25'd0, en});
        chk({tag, ".halt"}, {31'd0, bus.halt}, {31'd0, m_halted});
        chk({tag, ".luse"}, 32'(bus.luse_cnt), m_luse);
        chk({tag, ".wait"}, 32'(bus.wait_cnt), m_wait);
        @(posedge CLK);
        if (!RST) begin
            case (act)
                ActHalt: m_halted = 1;
                ActDrain, ActFreeze: begin
                    if (m_wait < CMAX) m_wait++;
                    if (bus.ihit) m_seen = 1;
                end
                ActBubble: begin
                    if (m_luse < CMAX) m_luse++;
                    m_seen = 0;
                end
                ActRedirect, ActRun: m_seen = 0;
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic drive(input bit ih, input bit dh, input bit mr, input bit redir,
                         input bit dren, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input bit urt, input bit mh);
        bus.ihit        = ih;
        bus.dhit        = dh;
        bus.mem_req     = mr;
        bus.ex_redirect = redir;
        bus.ex_dren     = dren;
        bus.ex_rt       = xrt;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_uses_rt  = urt;
        bus.mem_halt    = mh;
    endtask

    initial begin
        model_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset held with a fetch present.
        cycle("rst_hold");
        cycle("rst_hold2");
        RST = 1'b0;
        cycle("run");

        // Load-use bubble, then the same with rt=0 (no hazard).
        drive(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        cycle("luse");
        cycle("luse_after");
        drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle("luse_rt0");
        drive(1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
        cycle("luse_rt_field");

        // Memory wait with an ihit in the first cycle, then release on dhit only.
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("mwait1");
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("mwait2");
        cycle("mwait3");
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("mwait_rel");

        // Drain, then the redirect-during-stall freeze.
        cycle("drain");
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle("redir_freeze");

        // Redirect beats load-use.
        drive(1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        cycle("redir_lu");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("redir_after");

        // Halt, then inputs ignored until reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("halt_entry");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle("halted");
        RST = 1'b1;
        cycle("halt_rst");
        RST = 1'b0;

        // Saturate wait_cnt with a long freeze.
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CMAX + 8; i++) cycle("sat");
        @(negedge CLK);
        chk("wait_sat_const", 32'(bus.wait_cnt), CMAX);
        @(posedge CLK);
        if (m_wait < CMAX) m_wait++;
        #1;

        // Saturate luse_cnt with back-to-back bubbles.
        drive(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0);
        for (int i = 0; i < CMAX + 4; i++) cycle("luse_sat");

        // Mid-stall reset.
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("pre_rst_stall");
        RST = 1'b1;
        cycle("mid_stall_rst");
        RST = 1'b0;

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));
            RST = ($urandom_range(0, 24) == 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
